// File: rtl/zero_scan_pkg.sv
// rtl/zero_scan_pkg.sv - shared types and sizing for the zero/LZC scan unit
//
// Purpose: scan-controller state encoding and default geometry, shared by
// the RTL and its bench.
// Ports: none (package).
package zero_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scanState_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  // One extra bit so a count equal to the full width does not wrap.
  localparam int LZC_W  = $clog2(DEF_WIDTH) + 1;
  localparam int NCHUNK = DEF_WIDTH / DEF_CHUNK;

endpackage

// File: rtl/chunk_lzc.sv
// rtl/chunk_lzc.sv - combinational leading-zero count of one chunk
//
// Purpose: zero detect and leading-zero count for a CHUNK-bit slice.
// Ports:
//   chunk   in  CHUNK        slice to examine, MSB first
//   allZero out 1            slice is entirely zero
//   lz      out LzW          leading zeros; CHUNK when the slice is zero
module chunk_lzc #(
  parameter  int CHUNK = 8,
  localparam int LzW   = $clog2(CHUNK) + 1
) (
  input  logic [CHUNK-1:0] chunk,
  output logic             allZero,
  output logic [LzW-1:0]   lz
);

  always_comb begin
    allZero = ~|chunk;
    lz      = LzW'(CHUNK);
    // Walking up from the LSB, the last set bit seen is the most significant.
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk[i]) begin
        lz = LzW'(CHUNK - 1 - i);
      end
    end
  end

endmodule

// File: rtl/zero_scan.sv
// rtl/zero_scan.sv - multi-cycle zero detect and leading-zero count unit
//
// Purpose: captures a word on start, scans it CHUNK bits per cycle from the
// MSB, and reports is_zero/lzc with a fixed latency of WIDTH/CHUNK cycles.
// Ports:
//   clk      in  1        rising-edge clock
//   reset    in  1        asynchronous active-low reset
//   start    in  1        scan request, honoured only while not busy
//   data     in  WIDTH    word captured on the accepting edge
//   busy     out 1        high during SCAN
//   done     out 1        one-cycle pulse when the result updates
//   is_zero  out 1        last result: captured word was zero
//   lzc      out LzcW     last result: leading-zero count, 0..WIDTH
module zero_scan
  import zero_scan_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int CHUNK = DEF_CHUNK,
  localparam int LzcW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             is_zero,
  output logic [LzcW-1:0]  lzc
);

  localparam int NumChunk = WIDTH / CHUNK;
  localparam int CntW     = (NumChunk > 1) ? $clog2(NumChunk) : 1;
  localparam int ChunkLzW = $clog2(CHUNK) + 1;

  scanState_e          state;
  scanState_e          nextState;
  logic [WIDTH-1:0]    sh;
  logic [LzcW-1:0]     acc;
  logic [LzcW-1:0]     accNext;
  logic                found;
  logic [CntW-1:0]     cnt;
  logic                accept;
  logic                lastChunk;
  logic                chunkZero;
  logic [ChunkLzW-1:0] chunkLz;

  chunk_lzc #(
    .CHUNK(CHUNK)
  ) uChunkLzc (
    .chunk  (sh[WIDTH-1 -: CHUNK]),
    .allZero(chunkZero),
    .lz     (chunkLz)
  );

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    lastChunk = (cnt == CntW'(NumChunk - 1));
    // Once the first set bit has been seen, later chunks must not add to acc.
    accNext   = acc;
    if (!found) begin
      accNext = chunkZero ? acc + LzcW'(CHUNK) : acc + LzcW'(chunkLz);
    end
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          nextState = SCAN;
        end
      end
      SCAN: begin
        if (lastChunk) begin
          nextState = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          nextState = SCAN;
        end else begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sh      <= '0;
      acc     <= '0;
      found   <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      is_zero <= 1'b0;
      lzc     <= '0;
    end else begin
      state <= nextState;
      // Status flags are registered from the next state so they are glitch-free.
      busy  <= (nextState == SCAN);
      done  <= (nextState == DONE);
      if (accept) begin
        sh    <= data;
        acc   <= '0;
        found <= 1'b0;
        cnt   <= '0;
      end else if (state == SCAN) begin
        sh    <= sh << CHUNK;
        acc   <= accNext;
        found <= found | ~chunkZero;
        cnt   <= cnt + CntW'(1);
        if (lastChunk) begin
          lzc     <= accNext;
          is_zero <= (accNext == LzcW'(WIDTH));
        end
      end
    end
  end

endmodule

// File: tb/tb_zero_scan.sv
// tb/tb_zero_scan.sv - self-checking bench for zero_scan
module tb_zero_scan;
  import zero_scan_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int N = NCHUNK;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [W-1:0]     data = '0;
  logic             busy;
  logic             done;
  logic             is_zero;
  logic [LZC_W-1:0] lzc;

  int nChecks = 0;
  int nFail = 0;
  bit chkEn = 1'b0;

  always #5 clk = ~clk;

  zero_scan #(.WIDTH(W), .CHUNK(DEF_CHUNK)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .data   (data),
    .busy   (busy),
    .done   (done),
    .is_zero(is_zero),
    .lzc    (lzc)
  );

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clz(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      if (w[i]) return W - 1 - i;
    end
    return W;
  endfunction

  // Model: a request is taken when the unit is not busy; its result appears
  // with done exactly N edges after acceptance and then holds.
  bit eBusy = 1'b0;
  bit eDone = 1'b0;
  bit eZero = 1'b0;
  int eLzc = 0;
  bit active = 1'b0;
  int k = 0;
  int pendLzc = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      eBusy  = 1'b0;
      eDone  = 1'b0;
      eZero  = 1'b0;
      eLzc   = 0;
      active = 1'b0;
      k      = 0;
    end else begin
      if (start && !eBusy) begin
        active  = 1'b1;
        k       = 0;
        pendLzc = clz(data);
      end else if (active) begin
        k++;
      end
      eBusy = active && (k < N);
      eDone = active && (k == N);
      if (eDone) begin
        eLzc   = pendLzc;
        eZero  = (pendLzc == W);
        active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      check("cyc busy", int'(busy), int'(eBusy));
      check("cyc done", int'(done), int'(eDone));
      check("cyc is_zero", int'(is_zero), int'(eZero));
      check("cyc lzc", int'(lzc), eLzc);
    end
  end

  task automatic waitDone(input string name, input int expBusy, input int expLzc, input int expZero);
    int  nb = 0;
    bit  seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nb++;
    end
    check({name, " done seen"}, int'(seen), 1);
    check({name, " busy cycles"}, nb, expBusy);
    check({name, " lzc"}, int'(lzc), expLzc);
    check({name, " is_zero"}, int'(is_zero), expZero);
  endtask

  task automatic runScan(input string name, input logic [W-1:0] d, input int expLzc, input int expZero);
    @(posedge clk);
    #1;
    start = 1'b1;
    data  = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(name, N, expLzc, expZero);
  endtask

  initial begin
    int nDone;
    #1 reset = 1'b0;
    chkEn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset is_zero", int'(is_zero), 0);
    check("reset lzc", int'(lzc), 0);
    reset = 1'b1;

    runScan("zero", 32'h0000_0000, 32, 1);
    runScan("one", 32'h0000_0001, 31, 0);
    runScan("msb", 32'h8000_0000, 0, 0);
    runScan("bit16", 32'h0001_0000, 15, 0);
    runScan("f00", 32'h0000_0F00, 20, 0);

    // Second request during SCAN must be ignored.
    @(posedge clk);
    #1;
    start = 1'b1;
    data  = 32'h00FF_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    data  = 32'h0000_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("ignored", 2, 8, 0);
    repeat (2) @(negedge clk);
    check("ignored no rescan", int'(busy), 0);

    // Asynchronous reset in the middle of a scan.
    @(posedge clk);
    #1;
    start = 1'b1;
    data  = 32'h00FF_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort is_zero", int'(is_zero), 0);
    check("abort lzc", int'(lzc), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    nDone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) nDone++;
    end
    check("abort no done", nDone, 0);

    // Back-to-back: new request raised during the DONE cycle.
    runScan("b2b first", 32'h0000_0001, 31, 0);
    start = 1'b1;
    data  = 32'h0000_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("b2b second", N, 32, 1);

    repeat (3) @(posedge clk);
    #1;
    chkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
